// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and writeback.
// The slave side is the FIFO; the master side is producer plus consumer.
interface alu_result_fifo_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_uc;
    logic [WIDTH-1:0] in_result;
    logic             in_n;
    logic             in_z;
    logic             in_c;
    logic             in_v;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_nzcv;
    logic [4:0]       out_uc;

    modport master (
        output in_valid, in_uc, in_result,
        output in_n, in_z, in_c, in_v,
        output out_ready,
        input  in_ready, out_valid,
        input  out_result, out_nzcv, out_uc
    );

    modport slave (
        input  in_valid, in_uc, in_result,
        input  in_n, in_z, in_c, in_v,
        input  out_ready,
        output in_ready, out_valid,
        output out_result, out_nzcv, out_uc
    );
endinterface

// File: rtl/alu_result_fifo.sv
// ALU result/flag FIFO feeding writeback; also owns the NZCV register
// and the sticky overflow / illegal-op-code bits.
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_result_fifo_if.slave       bus,
    input  logic                   clr_sticky,
    output logic [3:0]             nzcv,
    output logic                   v_sticky,
    output logic                   err_sticky,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_res   [DEPTH];
    logic [3:0]       r_flags [DEPTH];
    logic [4:0]       r_uc    [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [3:0]       r_nzcv;
    logic             r_v_sticky;
    logic             r_err_sticky;

    logic             w_push;
    logic             w_pop;
    logic             w_legal;
    logic [3:0]       w_flags;

    // in_ready depends only on registered count, never on out_ready
    assign w_push  = bus.in_valid && (r_count != FULL);
    assign w_pop   = bus.out_ready && (r_count != '0);
    assign w_legal = bus.in_uc < 5'd5;
    assign w_flags = w_legal ?
                     {bus.in_n, bus.in_z, bus.in_c, bus.in_v} :
                     4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i]   <= '0;
                r_flags[i] <= '0;
                r_uc[i]    <= '0;
            end
        end else if (w_push) begin
            r_res[r_wr_ptr]   <= bus.in_result;
            r_flags[r_wr_ptr] <= w_flags;
            r_uc[r_wr_ptr]    <= bus.in_uc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A set in the same cycle as a clear leaves the sticky bit at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nzcv       <= '0;
            r_v_sticky   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_push && w_legal)
                r_nzcv <= w_flags;
            if (w_push && w_legal && bus.in_v)
                r_v_sticky <= 1'b1;
            else if (clr_sticky)
                r_v_sticky <= 1'b0;
            if (w_push && !w_legal)
                r_err_sticky <= 1'b1;
            else if (clr_sticky)
                r_err_sticky <= 1'b0;
        end
    end

    assign bus.in_ready   = (r_count != FULL);
    assign bus.out_valid  = (r_count != '0);
    assign bus.out_result = r_res[r_rd_ptr];
    assign bus.out_nzcv   = r_flags[r_rd_ptr];
    assign bus.out_uc     = r_uc[r_rd_ptr];
    assign nzcv           = r_nzcv;
    assign v_sticky       = r_v_sticky;
    assign err_sticky     = r_err_sticky;
    assign count          = r_count;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: driver pushes expectations,
// a negedge monitor pops and compares whatever the FIFO presents.
module tb_alu_result_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_sticky = 1'b0;
    logic [3:0]    nzcv;
    logic          v_sticky;
    logic          err_sticky;
    logic [CW-1:0] count;

    alu_result_fifo_if #(.WIDTH(WIDTH)) bus ();

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .nzcv       (nzcv),
        .v_sticky   (v_sticky),
        .err_sticky (err_sticky),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       f;
        logic [4:0]       uc;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend = 0;
    logic [3:0] m_nzcv = '0, n_nzcv = '0;
    bit   m_vs = 0, n_vs = 0, m_es = 0, n_es = 0;
    int   ec;
    ent_t e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries plus status expected after the edge
    task automatic step(bit v, logic [4:0] uc, logic [WIDTH-1:0] res,
                        logic [3:0] f, bit rdy, bit clr);
        bit acc, legal;
        @(posedge clk);
        #2;
        m_nzcv = n_nzcv; m_vs = n_vs; m_es = n_es; pend = 0;
        bus.in_valid  = v;
        bus.in_uc     = uc;
        bus.in_result = res;
        {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = f;
        bus.out_ready = rdy;
        clr_sticky    = clr;
        acc   = v && (sb.size() < DEPTH);
        legal = (uc <= 5'd4);
        if (acc) begin
            sb.push_back('{res, legal ? f : 4'b0000, uc});
            pend = 1;
            if (legal) n_nzcv = f;
        end
        if (acc && legal && f[0]) n_vs = 1;
        else if (clr)             n_vs = 0;
        if (acc && !legal)        n_es = 1;
        else if (clr)             n_es = 0;
    endtask

    task automatic idle(bit rdy);
        step(0, 5'd0, '0, 4'b0000, rdy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ec = sb.size() - int'(pend);
            chk("count", 32'(count), 32'(ec));
            chk("out_valid", 32'(bus.out_valid), 32'(ec != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(ec != DEPTH));
            chk("nzcv", 32'(nzcv), 32'(m_nzcv));
            chk("v_sticky", 32'(v_sticky), 32'(m_vs));
            chk("err_sticky", 32'(err_sticky), 32'(m_es));
            if (bus.out_valid && bus.out_ready) begin
                if (ec <= 0) begin
                    chk("pop_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_result", 32'(bus.out_result), 32'(e.res));
                    chk("out_nzcv", 32'(bus.out_nzcv), 32'(e.f));
                    chk("out_uc", 32'(bus.out_uc), 32'(e.uc));
                end
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_uc = '0; bus.in_result = '0;
        bus.in_n = 0; bus.in_z = 0; bus.in_c = 0; bus.in_v = 0;
        bus.out_ready = 0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_nzcv", 32'(nzcv), 32'(0));
        chk("rst_out_result", 32'(bus.out_result), 32'(0));
        chk("rst_out_nzcv", 32'(bus.out_nzcv), 32'(0));
        chk("rst_out_uc", 32'(bus.out_uc), 32'(0));
        #11 rst = 0;

        step(1, 5'd2, 4'h0, 4'b0110, 0, 0);
        idle(0);
        @(negedge clk); #1;
        chk("sum_valid", 32'(bus.out_valid), 32'(1));
        chk("sum_result", 32'(bus.out_result), 32'(0));
        chk("sum_out_nzcv", 32'(bus.out_nzcv), 32'(4'b0110));
        chk("sum_nzcv", 32'(nzcv), 32'(4'b0110));
        chk("sum_count", 32'(count), 32'(1));
        idle(1);

        for (int i = 1; i <= 4; i++)
            step(1, 5'd2, 4'(i), 4'(i), 0, 0);
        step(1, 5'd2, 4'h5, 4'b1111, 0, 0);
        idle(0);
        @(negedge clk); #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'(0));
        chk("full_count", 32'(count), 32'(4));
        chk("full_nzcv", 32'(nzcv), 32'(4));
        for (int i = 0; i < 4; i++) idle(1);
        idle(0);
        @(negedge clk); #1;
        chk("drained_valid", 32'(bus.out_valid), 32'(0));

        for (int i = 0; i < 10; i++)
            step(1, 5'd2, 4'(i), 4'(i), 1, 0);
        idle(1);

        step(1, 5'd3, 4'h3, 4'b0001, 1, 0);
        idle(1);
        @(negedge clk); #1;
        chk("ovf_nzcv_v1", 32'(nzcv[0]), 32'(1));
        step(1, 5'd0, 4'h1, 4'b0000, 1, 0);
        idle(1);
        @(negedge clk); #1;
        chk("ovf_nzcv_v0", 32'(nzcv[0]), 32'(0));
        chk("ovf_sticky_hold", 32'(v_sticky), 32'(1));
        step(0, 5'd0, '0, 4'b0000, 1, 1);
        idle(1);
        @(negedge clk); #1;
        chk("ovf_sticky_clr", 32'(v_sticky), 32'(0));
        step(1, 5'd3, 4'h7, 4'b0001, 1, 1);
        idle(1);
        @(negedge clk); #1;
        chk("ovf_set_wins", 32'(v_sticky), 32'(1));

        step(1, 5'd0, 4'h8, 4'b1000, 0, 0);
        idle(1);
        step(1, 5'b11111, 4'hA, 4'b1111, 0, 0);
        idle(0);
        @(negedge clk); #1;
        chk("ill_out_nzcv", 32'(bus.out_nzcv), 32'(0));
        chk("ill_out_result", 32'(bus.out_result), 32'(4'hA));
        chk("ill_nzcv", 32'(nzcv), 32'(4'b1000));
        chk("ill_err_sticky", 32'(err_sticky), 32'(1));
        idle(1);

        for (int i = 0; i < 3; i++)
            step(1, 5'd1, 4'(i + 9), 4'b1010, 0, 0);
        idle(0);
        @(posedge clk); #2;
        m_nzcv = n_nzcv; m_vs = n_vs; m_es = n_es; pend = 0;
        #1 rst = 1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_nzcv", 32'(nzcv), 32'(0));
        chk("arst_out_result", 32'(bus.out_result), 32'(0));
        sb.delete();
        m_nzcv = '0; n_nzcv = '0;
        m_vs = 0; n_vs = 0; m_es = 0; n_es = 0;
        @(negedge clk); #1 rst = 0;
        step(1, 5'd2, 4'h7, 4'b0001, 0, 0);
        idle(0);
        @(negedge clk); #1;
        chk("post_rst_head", 32'(bus.out_result), 32'(4'h7));
        chk("post_rst_count", 32'(count), 32'(1));
        idle(1);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 WIDTH'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
        for (int i = 0; i < DEPTH + 2; i++) idle(1);
        @(negedge clk); #1;
        chk("final_empty", 32'(bus.out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Buffers ALU results and flags in a small FIFO, and maintains the architectural NZCV status register. It sits directly downstream of the ALU, capturing `result`, `n`, `z`, `c`, `v` and the op code that produced them. It presents them to the writeback stage over a valid/ready handshake, so the ALU can keep issuing while writeback stalls.

## Interface
- `WIDTH`, 4, data width; matches the ALU `WIDTH`.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  ALU output is a real operation this cycle
- `in_ready`  out  1  FIFO can accept an entry
- `in_uc`  in  5  op code the ALU executed
- `in_result`  in  WIDTH  ALU result
- `in_n`, `in_z`, `in_c`, `in_v`  in  1 each  ALU flags
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer takes head entry
- `out_result`  out  WIDTH  head result
- `out_nzcv`  out  4  head flags, {n,z,c,v}
- `out_uc`  out  5  head op code
- `nzcv`  out  4  status register, {N,Z,C,V}
- `v_sticky`  out  1  sticky overflow
- `err_sticky`  out  1  sticky illegal-op-code
- `clr_sticky`  in  1  clears both sticky bits
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- **Push** occurs when `in_valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- **Pop** occurs when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- `in_ready = (count != DEPTH)`, registered-state only. There is no combinational path from `out_ready`. When full, the FIFO refuses a push even if a pop happens in the same cycle.
- `out_valid = (count != 0)`. `out_*` are driven from storage at `rd_ptr`.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance.
- **Legal op codes** are 0..4 (AND, OR, SUM, RESTA, XOR). On a push with a legal op:
  - the stored flags are `{in_n,in_z,in_c,in_v}`;
  - `nzcv` loads the same value;
  - `v_sticky` is set if `in_v = 1`.
- **Illegal op code (≥ 5):** the entry is stored with `in_result` and flags forced to `4'b0000`. `nzcv` is unchanged and `err_sticky` is set.
- **Sticky bits:** `clr_sticky` clears both. If a clear and a set land in the same cycle, the set wins (the bit ends at 1).
- **No push** (`in_valid = 0` or FIFO full): `nzcv` and the sticky bits are unchanged. A push refused because the FIFO is full does not update the status.
- A pop has no effect on `nzcv` or the sticky bits.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - pointers, `count`, `nzcv`, `v_sticky` and `err_sticky` go to 0;
  - `out_valid = 0`, `in_ready = 1`;
  - `out_result`, `out_nzcv`, `out_uc` read 0, because storage is cleared on reset.
- **Reset mid-operation:** all entries are discarded, and there is no partial pop.
- **Latency:** an entry pushed at edge k is visible on `out_*` with `out_valid = 1` after edge k. A consumer with `out_ready = 1` pops it at edge k+1.
- **Status:** `nzcv` updates at the same edge as the push. There is no bypass: `nzcv` reflects the most recently pushed legal op, not the head entry.
- **Throughput:** one push and one pop per cycle while 0 < `count` < DEPTH.
- **Empty:** a pop is ignored (`out_valid = 0`). **Full:** a push is ignored (`in_ready = 0`). Neither corrupts pointers or `count`.
- **Wrap-around:** pointers use `$clog2(DEPTH)` bits and overflow naturally. `count` alone distinguishes full from empty.

## Test plan
- **Reset, then single SUM:** `in_uc = 2`, result `4'h0`, n=0 z=1 c=1 v=0, `out_ready = 0`.
  - Next cycle: `out_valid = 1`, `out_result = 0`, `out_nzcv = 4'b0110`, `nzcv = 4'b0110`, `count = 1`.
- **Fill and block:** push 4 entries with results 1,2,3,4 while `out_ready = 0`.
  - Required: `in_ready = 0`, `count = 4`.
  - A 5th `in_valid` with result 5 is dropped and `nzcv` is unchanged.
  - Then drain with `out_ready = 1`: outputs are 1,2,3,4 in order, and `out_valid` falls after the 4th pop.
- **Streaming with wrap:** hold `in_valid = 1` and `out_ready = 1` for 10 cycles with results 0..9 (`WIDTH` 4).
  - Required: `count` stays at 1 after the first cycle, outputs are 0..9 in order, and pointers wrap twice without loss.
- **Overflow sticky:** push a RESTA with v=1, then an AND with v=0.
  - Required: `nzcv[0]` becomes 1, then 0; `v_sticky` stays 1.
  - Assert `clr_sticky` alone: `v_sticky` becomes 0.
  - Assert `clr_sticky` together with a v=1 push: `v_sticky` becomes 1.
- **Illegal op code:** with `nzcv = 4'b1000`, push `in_uc = 5'b11111`, result `4'hA`, flags 1111.
  - Required: stored `out_nzcv = 0000`, `out_result = 4'hA`, `nzcv` stays `1000`, `err_sticky = 1`.
- **Async reset mid-stream:** with `count = 3`, assert `rst` between clock edges.
  - Required: `out_valid` falls immediately, `count = 0`, `nzcv = 0`.
  - After release, the first new push appears at the head (no stale data).
